// File: rtl/johnson_seq_decoder.sv
// Johnson code stream monitor: decodes each sampled word to its step index,
// flags illegal words and out-of-order steps, and tracks sequence lock.
module johnson_seq_decoder #(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  localparam int IDXW     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic [IDXW-1:0]  index,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam int              RUNW     = $clog2(LOCK_CNT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT,
    CONFIRM,
    LOCKED
  } state_t;

  state_t          state_q;
  logic [RUNW-1:0] run_q;
  logic [IDXW-1:0] lastIdx_q;
  logic [IDXW-1:0] index_q;
  logic            indexValid_q;
  logic            illegal_q;
  logic            seqErr_q;
  logic            wrap_q;
  logic [7:0]      errCount_q;

  logic [WIDTH-2:0] edges;
  logic             legal;
  logic             isSucc;
  logic             errEvent;
  logic [IDXW-1:0]  idx_d;
  logic [IDXW-1:0]  succIdx;
  logic [RUNW-1:0]  run_d;
  int               ones;

  // A legal Johnson word has at most one 0/1 boundary along its bits; the
  // boundary position plus the LSB value pins down the step uniquely.
  always_comb begin
    edges = code_in[WIDTH-1:1] ^ code_in[WIDTH-2:0];
    legal = $onehot0(edges);
    ones  = $countones(code_in);
    if (code_in == '0) begin
      idx_d = '0;
    end else if (code_in[0]) begin
      idx_d = IDXW'(ones);
    end else begin
      idx_d = IDXW'(2 * WIDTH - ones);
    end
    succIdx  = (lastIdx_q == LAST_IDX) ? '0 : lastIdx_q + IDXW'(1);
    isSucc   = legal && (idx_d == succIdx);
    errEvent = code_valid && (!legal || ((state_q == LOCKED) && !isSucc));
    run_d    = run_q + RUNW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      run_q        <= '0;
      lastIdx_q    <= '0;
      index_q      <= '0;
      indexValid_q <= 1'b0;
      illegal_q    <= 1'b0;
      seqErr_q     <= 1'b0;
      wrap_q       <= 1'b0;
      errCount_q   <= '0;
    end else begin
      indexValid_q <= 1'b0;
      illegal_q    <= 1'b0;
      seqErr_q     <= 1'b0;
      wrap_q       <= 1'b0;
      if (errEvent && (errCount_q != 8'hFF)) begin
        errCount_q <= errCount_q + 8'd1;
      end
      if (code_valid) begin
        if (!legal) begin
          illegal_q <= 1'b1;
          state_q   <= HUNT;
          run_q     <= '0;
        end else begin
          index_q      <= idx_d;
          indexValid_q <= 1'b1;
          lastIdx_q    <= idx_d;
          case (state_q)
            HUNT: begin
              state_q <= CONFIRM;
              run_q   <= '0;
            end
            CONFIRM: begin
              if (isSucc) begin
                run_q <= run_d;
                if (run_d >= RUNW'(LOCK_CNT)) begin
                  state_q <= LOCKED;
                end
              end else begin
                run_q <= '0;
              end
            end
            LOCKED: begin
              if (isSucc) begin
                wrap_q <= (lastIdx_q == LAST_IDX) && (idx_d == '0);
              end else begin
                seqErr_q <= 1'b1;
                state_q  <= CONFIRM;
                run_q    <= '0;
              end
            end
            default: begin
              state_q <= HUNT;
              run_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign index       = index_q;
  assign index_valid = indexValid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seqErr_q;
  assign wrap        = wrap_q;
  assign locked      = (state_q == LOCKED);
  assign err_count   = errCount_q;

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// Bench for johnson_seq_decoder: a table-driven reference model pushes the
// expected output word per cycle into a scoreboard that each test pops and checks.
module tb_johnson_seq_decoder;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;

  typedef struct packed {
    logic [2:0] idx;
    logic       iv;
    logic       ill;
    logic       se;
    logic       wr;
    logic       lk;
    logic [7:0] ec;
  } obs_t;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code_in    = 4'b0000;
  logic [2:0] index;
  logic       index_valid, illegal, seq_err, wrap, locked;
  logic [7:0] err_count;

  johnson_seq_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .index      (index),
    .index_valid(index_valid),
    .illegal    (illegal),
    .seq_err    (seq_err),
    .wrap       (wrap),
    .locked     (locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  obs_t       sb[$];
  int         nChecks = 0;
  int         nPass   = 0;
  logic [3:0] seqTab[8];

  // Reference model state: 0 = hunt, 1 = confirm, 2 = locked.
  int         mState = 0;
  int         mRun   = 0;
  int         mLast  = 0;
  logic [2:0] mIndex = 3'd0;
  logic [7:0] mErr   = 8'd0;

  function automatic int johnsonPos(input logic [3:0] c);
    for (int k = 0; k < 8; k++) begin
      if (seqTab[k] === c) return k;
    end
    return -1;
  endfunction

  function automatic obs_t sample();
    return {index, index_valid, illegal, seq_err, wrap, locked, err_count};
  endfunction

  // Drives one cycle of stimulus, advances the model and queues its prediction.
  task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] c);
    obs_t e;
    int   p;
    logic succ;
    @(negedge clk);
    reset      = rst;
    code_valid = v;
    code_in    = c;
    e = '0;
    if (rst) begin
      mState = 0; mRun = 0; mLast = 0; mIndex = 3'd0; mErr = 8'd0;
    end else if (v) begin
      p = johnsonPos(c);
      if (p < 0) begin
        e.ill  = 1'b1;
        if (mErr != 8'hFF) mErr = mErr + 8'd1;
        mState = 0;
        mRun   = 0;
      end else begin
        succ   = (p == (mLast + 1) % 8);
        e.iv   = 1'b1;
        mIndex = 3'(p);
        case (mState)
          0: begin mState = 1; mRun = 0; end
          1: begin
            if (succ) begin
              mRun++;
              if (mRun >= LOCK_CNT) mState = 2;
            end else begin
              mRun = 0;
            end
          end
          default: begin
            if (succ) begin
              e.wr = (mLast == 7) && (p == 0);
            end else begin
              e.se = 1'b1;
              if (mErr != 8'hFF) mErr = mErr + 8'd1;
              mState = 1;
              mRun   = 0;
            end
          end
        endcase
        mLast = p;
      end
    end
    e.idx = mIndex;
    e.lk  = (mState == 2);
    e.ec  = mErr;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t exp, got;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0111);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL reset[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
    end
    nChecks++;
    if (locked !== 1'b0 || err_count !== 8'd0)
      $display("[TB] FAIL reset_levels got locked=%b err=%0d want locked=0 err=0", locked, err_count);
    else nPass++;
  endtask

  task automatic test_lock();
    obs_t exp, got;
    logic [3:0] stim[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, stim[i]);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL lock[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
    end
    nChecks++;
    if (locked !== 1'b1 || index !== 3'd3)
      $display("[TB] FAIL lock_final got locked=%b idx=%0d want locked=1 idx=3", locked, index);
    else nPass++;
  endtask

  task automatic test_wrap();
    obs_t exp, got;
    logic [3:0] stim[5] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, stim[i]);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL wrap[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
    end
    nChecks++;
    if (wrap !== 1'b1 || index !== 3'd0)
      $display("[TB] FAIL wrap_pulse got wrap=%b idx=%0d want wrap=1 idx=0", wrap, index);
    else nPass++;
  endtask

  task automatic test_seq_err();
    obs_t exp, got;
    logic [3:0] stim[6] = '{4'b0001, 4'b0011, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, stim[i]);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL seq_err[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
      if (i == 2) begin
        nChecks++;
        if (seq_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || index !== 3'd4)
          $display("[TB] FAIL skip_report got se=%b err=%0d lk=%b idx=%0d want se=1 err=1 lk=0 idx=4",
                   seq_err, err_count, locked, index);
        else nPass++;
      end
    end
  endtask

  task automatic test_illegal();
    obs_t exp, got;
    applyStimulus(1'b0, 1'b1, 4'b0101);
    exp = sb.pop_front(); got = sample(); nChecks++;
    if (got !== exp) $display("[TB] FAIL illegal got=%h want=%h", got, exp);
    else nPass++;
    nChecks++;
    if (illegal !== 1'b1 || seq_err !== 1'b0 || index !== 3'd7 || err_count !== 8'd2 || locked !== 1'b0)
      $display("[TB] FAIL illegal_fields got ill=%b se=%b idx=%0d err=%0d lk=%b want 1 0 7 2 0",
               illegal, seq_err, index, err_count, locked);
    else nPass++;
  endtask

  task automatic test_hold();
    obs_t exp, got;
    logic       vTab[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] cTab[7] = '{4'b0000, 4'b0001, 4'b0101, 4'b1111, 4'b1001, 4'b0011, 4'b0111};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, vTab[i], cTab[i]);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL hold[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp, got;
    logic       v;
    logic [3:0] c;
    for (int i = 0; i < 80; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) < 7) ? seqTab[(mLast + 1) % 8] : 4'($urandom_range(0, 15));
      applyStimulus(1'b0, v, c);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL b2b[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
    end
  endtask

  task automatic test_saturation();
    obs_t exp, got;
    logic [3:0] c;
    for (int i = 0; i < 300; i++) begin
      c = 4'b0101;
      for (int k = 0; k < 16; k++) begin
        c = 4'($urandom_range(0, 15));
        if (johnsonPos(c) < 0) break;
        c = 4'b1010;
      end
      applyStimulus(1'b0, 1'b1, c);
      exp = sb.pop_front(); got = sample(); nChecks++;
      if (got !== exp) $display("[TB] FAIL sat[%0d] got=%h want=%h", i, got, exp);
      else nPass++;
    end
    nChecks++;
    if (err_count !== 8'd255)
      $display("[TB] FAIL sat_level got err=%0d want err=255", err_count);
    else nPass++;
    applyStimulus(1'b1, 1'b1, 4'b1011);
    exp = sb.pop_front(); got = sample(); nChecks++;
    if (got !== exp) $display("[TB] FAIL mid_reset got=%h want=%h", got, exp);
    else nPass++;
    nChecks++;
    if (err_count !== 8'd0 || locked !== 1'b0 || illegal !== 1'b0)
      $display("[TB] FAIL mid_reset_levels got err=%0d lk=%b ill=%b want 0 0 0", err_count, locked, illegal);
    else nPass++;
    applyStimulus(1'b0, 1'b1, 4'b1100);
    exp = sb.pop_front(); got = sample(); nChecks++;
    if (got !== exp) $display("[TB] FAIL post_reset got=%h want=%h", got, exp);
    else nPass++;
  endtask

  initial begin
    seqTab[0] = 4'b0000;
    for (int k = 1; k < 8; k++) seqTab[k] = {seqTab[k-1][2:0], ~seqTab[k-1][3]};
    test_reset();
    test_lock();
    test_wrap();
    test_seq_err();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
